// File: rtl/bus_demux_2_targets.sv
// Routes one initiator memory bus to RAM (target 0) or MMIO (target 1).
// Read responses come back in order; a target switch waits for the drain.
module bus_demux_2_targets #(
  parameter logic [31:0] T1_BASE   = 32'h8000_0000,
  parameter logic [31:0] T1_MASK   = 32'hF000_0000,
  parameter int unsigned MAX_OUTST = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic        req_we,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_wstrb,
  output logic        t0_valid,
  input  logic        t0_ready,
  output logic [31:0] t0_addr,
  output logic        t0_we,
  output logic [31:0] t0_wdata,
  output logic [3:0]  t0_wstrb,
  input  logic        t0_rsp_valid,
  input  logic [31:0] t0_rsp_rdata,
  output logic        t1_valid,
  input  logic        t1_ready,
  output logic [31:0] t1_addr,
  output logic        t1_we,
  output logic [31:0] t1_wdata,
  output logic [3:0]  t1_wstrb,
  input  logic        t1_rsp_valid,
  input  logic [31:0] t1_rsp_rdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        err
);

  localparam logic [2:0] LP_MAX = 3'(MAX_OUTST);

  logic [2:0] r_outst_cnt;
  logic       r_cur_tgt;
  logic       r_err;

  logic       w_sel;
  logic       w_idle;
  logic       w_cur_rsp;
  logic       w_oth_rsp;
  logic       w_rsp_valid;
  logic       w_room;
  logic       w_gate;
  logic       w_tgt_ready;
  logic       w_accept;
  logic       w_err_evt;
  logic [2:0] w_cnt_nxt;

  assign w_sel  = (req_addr & T1_MASK) == T1_BASE;
  assign w_idle = (r_outst_cnt == 3'd0);

  assign w_cur_rsp   = r_cur_tgt ? t1_rsp_valid : t0_rsp_valid;
  assign w_oth_rsp   = r_cur_tgt ? t0_rsp_valid : t1_rsp_valid;
  assign w_rsp_valid = w_cur_rsp & ~w_idle;

  // a response retiring this cycle frees a slot for a same-target request
  assign w_room = (r_outst_cnt < LP_MAX) | w_rsp_valid;
  assign w_gate = w_idle | ((w_sel == r_cur_tgt) & w_room);

  assign w_tgt_ready = w_sel ? t1_ready : t0_ready;
  assign req_ready   = w_tgt_ready & w_gate;
  assign w_accept    = req_valid & req_ready;

  assign t0_valid = req_valid & w_gate & ~w_sel;
  assign t1_valid = req_valid & w_gate & w_sel;

  assign t0_addr  = req_addr;
  assign t0_we    = req_we;
  assign t0_wdata = req_wdata;
  assign t0_wstrb = req_wstrb;
  assign t1_addr  = req_addr;
  assign t1_we    = req_we;
  assign t1_wdata = req_wdata;
  assign t1_wstrb = req_wstrb;

  assign rsp_valid = w_rsp_valid;
  assign rsp_rdata = !w_rsp_valid ? 32'h0 :
                     r_cur_tgt    ? t1_rsp_rdata :
                                    t0_rsp_rdata;

  assign w_err_evt = w_oth_rsp |
                     (w_idle & (t0_rsp_valid | t1_rsp_valid));

  always_comb begin
    w_cnt_nxt = r_outst_cnt;
    unique case ({w_accept, w_rsp_valid})
      2'b10:   w_cnt_nxt = r_outst_cnt + 3'd1;
      2'b01:   w_cnt_nxt = r_outst_cnt - 3'd1;
      default: w_cnt_nxt = r_outst_cnt;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_outst_cnt <= 3'd0;
      r_cur_tgt   <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_outst_cnt <= w_cnt_nxt;
      if (w_accept)
        r_cur_tgt <= w_sel;
      if (w_err_evt)
        r_err <= 1'b1;
    end
  end

  assign err = r_err;

endmodule

// File: tb/tb_bus_demux_2_targets.sv
// Bench for bus_demux_2_targets: decode table plus scoreboarded
// multi-cycle sequences (limit, target switch, errors, async reset).
module tb_bus_demux_2_targets;

  logic        clk;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic        req_we;
  logic [31:0] req_wdata;
  logic [3:0]  req_wstrb;
  logic        t0_valid, t0_ready, t0_we, t0_rsp_valid;
  logic [31:0] t0_addr, t0_wdata, t0_rsp_rdata;
  logic [3:0]  t0_wstrb;
  logic        t1_valid, t1_ready, t1_we, t1_rsp_valid;
  logic [31:0] t1_addr, t1_wdata, t1_rsp_rdata;
  logic [3:0]  t1_wstrb;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        err;

  int n_chk;
  int n_fail;

  typedef struct {
    logic        tgt;
    logic [31:0] data;
  } pend_t;

  pend_t       pend_q[$];
  logic [31:0] exp_q[$];

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        t0r;
    logic        t1r;
    logic        e_t0v;
    logic        e_t1v;
    logic        e_rdy;
  } vec_t;

  vec_t vecs[6];

  bus_demux_2_targets dut (
    .clk          (clk),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_addr     (req_addr),
    .req_we       (req_we),
    .req_wdata    (req_wdata),
    .req_wstrb    (req_wstrb),
    .t0_valid     (t0_valid),
    .t0_ready     (t0_ready),
    .t0_addr      (t0_addr),
    .t0_we        (t0_we),
    .t0_wdata     (t0_wdata),
    .t0_wstrb     (t0_wstrb),
    .t0_rsp_valid (t0_rsp_valid),
    .t0_rsp_rdata (t0_rsp_rdata),
    .t1_valid     (t1_valid),
    .t1_ready     (t1_ready),
    .t1_addr      (t1_addr),
    .t1_we        (t1_we),
    .t1_wdata     (t1_wdata),
    .t1_wstrb     (t1_wstrb),
    .t1_rsp_valid (t1_rsp_valid),
    .t1_rsp_rdata (t1_rsp_rdata),
    .rsp_valid    (rsp_valid),
    .rsp_rdata    (rsp_rdata),
    .err          (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic tb_sel(input logic [31:0] a);
    return (a & 32'hF000_0000) == 32'h8000_0000;
  endfunction

  function automatic logic [31:0] model_data(input logic [31:0] a,
                                             input logic w);
    if (w) return 32'h0;
    if (a == 32'h0000_0100) return 32'hDEAD_BEEF;
    return a ^ 32'hC0DE_0000;
  endfunction

  task automatic chk1(input string nm, input logic act, input logic exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", nm, act, exp);
    end
  endtask

  task automatic chk32(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // observe handshakes before the edge, then advance one cycle
  task automatic step();
    logic [31:0] d;
    pend_t       p;
    #2;
    if (req_valid && req_ready) begin
      chk1("acc_tgt_valid", tb_sel(req_addr) ? t1_valid : t0_valid, 1'b1);
      d = model_data(req_addr, req_we);
      p.tgt  = tb_sel(req_addr);
      p.data = d;
      pend_q.push_back(p);
      exp_q.push_back(d);
    end
    if (rsp_valid) begin
      if (exp_q.size() == 0)
        chk1("rsp_unexpected", 1'b1, 1'b0);
      else
        chk32("rsp_rdata", rsp_rdata, exp_q.pop_front());
    end
    @(negedge clk);
    req_valid    = 1'b0;
    t0_rsp_valid = 1'b0;
    t1_rsp_valid = 1'b0;
    t0_rsp_rdata = 32'h0;
    t1_rsp_rdata = 32'h0;
  endtask

  // the oldest outstanding target returns its response this cycle
  task automatic respond();
    pend_t p;
    if (pend_q.size() == 0) begin
      chk1("respond_nothing_pending", 1'b1, 1'b0);
    end else begin
      p = pend_q.pop_front();
      if (p.tgt) begin
        t1_rsp_valid = 1'b1;
        t1_rsp_rdata = p.data;
      end else begin
        t0_rsp_valid = 1'b1;
        t0_rsp_rdata = p.data;
      end
    end
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    reset        = 1'b1;
    req_valid    = 1'b0;
    req_addr     = 32'h0;
    req_we       = 1'b0;
    req_wdata    = 32'h0;
    req_wstrb    = 4'h0;
    t0_ready     = 1'b0;
    t1_ready     = 1'b0;
    t0_rsp_valid = 1'b0;
    t1_rsp_valid = 1'b0;
    t0_rsp_rdata = 32'h0;
    t1_rsp_rdata = 32'h0;

    vecs[0] = '{32'h0000_0100, 1'b0, 32'h0,         4'hF, 1'b1, 1'b1,
                1'b1, 1'b0, 1'b1};
    vecs[1] = '{32'h8000_0004, 1'b1, 32'hA5A5_5A5A, 4'h3, 1'b1, 1'b1,
                1'b0, 1'b1, 1'b1};
    vecs[2] = '{32'h8FFF_FFFC, 1'b0, 32'h0,         4'hF, 1'b1, 1'b0,
                1'b0, 1'b1, 1'b0};
    vecs[3] = '{32'h7FFF_FFFF, 1'b1, 32'h1234_5678, 4'h8, 1'b0, 1'b1,
                1'b1, 1'b0, 1'b0};
    vecs[4] = '{32'h9000_0000, 1'b1, 32'hFFFF_0000, 4'hC, 1'b1, 1'b0,
                1'b1, 1'b0, 1'b1};
    vecs[5] = '{32'hF000_0000, 1'b0, 32'h0,         4'h1, 1'b1, 1'b1,
                1'b1, 1'b0, 1'b1};

    repeat (2) @(negedge clk);
    chk1("rst_rsp_valid", rsp_valid, 1'b0);
    chk1("rst_err", err, 1'b0);
    chk1("rst_t0_valid", t0_valid, 1'b0);
    chk1("rst_t1_valid", t1_valid, 1'b0);
    chk1("rst_req_ready", req_ready, 1'b0);
    chk32("rst_cnt", 32'(dut.r_outst_cnt), 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // decode / forwarding table, valid dropped before the edge
    for (int i = 0; i < 6; i++) begin
      req_addr  = vecs[i].addr;
      req_we    = vecs[i].we;
      req_wdata = vecs[i].wdata;
      req_wstrb = vecs[i].wstrb;
      t0_ready  = vecs[i].t0r;
      t1_ready  = vecs[i].t1r;
      req_valid = 1'b1;
      #1;
      chk1($sformatf("vec%0d_t0_valid", i), t0_valid, vecs[i].e_t0v);
      chk1($sformatf("vec%0d_t1_valid", i), t1_valid, vecs[i].e_t1v);
      chk1($sformatf("vec%0d_req_ready", i), req_ready, vecs[i].e_rdy);
      chk32($sformatf("vec%0d_t0_addr", i), t0_addr, vecs[i].addr);
      chk32($sformatf("vec%0d_t1_wdata", i), t1_wdata, vecs[i].wdata);
      chk32($sformatf("vec%0d_t0_wstrb", i), 32'(t0_wstrb),
            32'(vecs[i].wstrb));
      chk1($sformatf("vec%0d_t1_we", i), t1_we, vecs[i].we);
      req_valid = 1'b0;
      @(negedge clk);
    end

    // single RAM read
    t0_ready  = 1'b1;
    t1_ready  = 1'b1;
    req_addr  = 32'h0000_0100;
    req_we    = 1'b0;
    req_wstrb = 4'hF;
    req_valid = 1'b1;
    #1;
    chk1("t1_read_t0_valid", t0_valid, 1'b1);
    chk1("t1_read_t1_valid", t1_valid, 1'b0);
    step();
    chk32("t1_cnt_after_req", 32'(dut.r_outst_cnt), 32'd1);
    respond();
    #1;
    chk1("t1_rsp_valid", rsp_valid, 1'b1);
    chk32("t1_rsp_rdata", rsp_rdata, 32'hDEAD_BEEF);
    step();
    chk32("t1_cnt_after_rsp", 32'(dut.r_outst_cnt), 32'd0);

    // single MMIO write
    req_addr  = 32'h8000_0004;
    req_we    = 1'b1;
    req_wdata = 32'h1234_5678;
    req_wstrb = 4'b0011;
    req_valid = 1'b1;
    #1;
    chk1("t2_t1_valid", t1_valid, 1'b1);
    chk1("t2_t0_valid", t0_valid, 1'b0);
    chk32("t2_t1_addr", t1_addr, 32'h8000_0004);
    chk32("t2_t1_wdata", t1_wdata, 32'h1234_5678);
    chk32("t2_t1_wstrb", 32'(t1_wstrb), 32'h3);
    chk1("t2_t1_we", t1_we, 1'b1);
    step();
    respond();
    #1;
    chk1("t2_rsp_valid", rsp_valid, 1'b1);
    step();
    chk1("t2_err", err, 1'b0);

    // outstanding limit
    req_we = 1'b0;
    for (int i = 0; i < 4; i++) begin
      req_addr  = 32'h200 + 32'(i * 4);
      req_valid = 1'b1;
      step();
    end
    chk32("t3_cnt_full", 32'(dut.r_outst_cnt), 32'd4);
    req_addr  = 32'h300;
    req_valid = 1'b1;
    #1;
    chk1("t3_full_ready", req_ready, 1'b0);
    chk1("t3_full_t0_valid", t0_valid, 1'b0);
    step();
    req_valid = 1'b1;
    #1;
    chk1("t3_full_ready2", req_ready, 1'b0);
    step();
    req_valid = 1'b1;
    respond();
    #1;
    chk1("t3_ready_with_rsp", req_ready, 1'b1);
    chk1("t3_rsp_valid", rsp_valid, 1'b1);
    step();
    chk32("t3_cnt_same", 32'(dut.r_outst_cnt), 32'd4);
    repeat (4) begin
      respond();
      step();
    end
    chk32("t3_cnt_drained", 32'(dut.r_outst_cnt), 32'd0);

    // target switch waits for drain
    req_addr  = 32'h400;
    req_valid = 1'b1;
    step();
    chk32("t4_cnt", 32'(dut.r_outst_cnt), 32'd1);
    req_addr  = 32'h8000_0000;
    req_valid = 1'b1;
    #1;
    chk1("t4_blocked_ready", req_ready, 1'b0);
    chk1("t4_blocked_t1_valid", t1_valid, 1'b0);
    step();
    req_valid = 1'b1;
    respond();
    #1;
    chk1("t4_rsp_cycle_ready", req_ready, 1'b0);
    chk1("t4_rsp_cycle_rsp", rsp_valid, 1'b1);
    step();
    req_valid = 1'b1;
    #1;
    chk1("t4_switch_ready", req_ready, 1'b1);
    chk1("t4_switch_t1_valid", t1_valid, 1'b1);
    step();
    chk1("t4_cur_tgt", dut.r_cur_tgt, 1'b1);
    respond();
    step();
    chk32("t4_cnt_end", 32'(dut.r_outst_cnt), 32'd0);
    chk1("t4_cur_tgt_hold", dut.r_cur_tgt, 1'b1);

    // response from the wrong target
    req_addr  = 32'h500;
    req_valid = 1'b1;
    step();
    t1_rsp_valid = 1'b1;
    t1_rsp_rdata = 32'hBAD0_BAD0;
    #1;
    chk1("t5_bad_rsp_valid", rsp_valid, 1'b0);
    chk32("t5_bad_rsp_rdata", rsp_rdata, 32'h0);
    step();
    chk1("t5_err", err, 1'b1);
    chk32("t5_cnt", 32'(dut.r_outst_cnt), 32'd1);
    respond();
    step();
    chk32("t5_cnt_end", 32'(dut.r_outst_cnt), 32'd0);
    chk1("t5_err_sticky", err, 1'b1);

    // asynchronous reset mid-transaction
    for (int i = 0; i < 3; i++) begin
      req_addr  = 32'h600 + 32'(i * 4);
      req_valid = 1'b1;
      step();
    end
    chk32("t6_cnt_pre", 32'(dut.r_outst_cnt), 32'd3);
    t0_rsp_valid = 1'b1;
    t0_rsp_rdata = 32'h0000_0600 ^ 32'hC0DE_0000;
    #1;
    chk1("t6_rsp_pre", rsp_valid, 1'b1);
    #1;
    reset = 1'b1;
    #1;
    chk32("t6_cnt_async", 32'(dut.r_outst_cnt), 32'd0);
    chk1("t6_err_async", err, 1'b0);
    chk1("t6_rsp_async", rsp_valid, 1'b0);
    t0_rsp_valid = 1'b0;
    pend_q.delete();
    exp_q.delete();
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    t0_rsp_valid = 1'b1;
    t0_rsp_rdata = 32'h1111_1111;
    #1;
    chk1("t6_late_rsp_valid", rsp_valid, 1'b0);
    step();
    chk1("t6_late_err", err, 1'b1);
    chk32("t6_late_cnt", 32'(dut.r_outst_cnt), 32'd0);
    chk32("sb_empty", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
